// File: rtl/cam_capture_ctrl.sv
// Camera frame-capture sequencer with a round-robin register arbiter for the
// NIOS (nr_*) and HPS (hr_*) masters sharing one small register file.
module cam_capture_ctrl #(
    parameter int LINE_W = 16,
    parameter int PIX_W  = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_pixsync,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic        vid_visible,
    input  logic        vid_locked,
    input  logic [1:0]  nr_address,
    input  logic        nr_bus_enable,
    input  logic        nr_rw,
    input  logic [31:0] nr_write_data,
    output logic [31:0] nr_read_data,
    output logic        nr_acknowledge,
    output logic        nr_irq,
    input  logic [1:0]  hr_address,
    input  logic        hr_bus_enable,
    input  logic        hr_rw,
    input  logic [31:0] hr_write_data,
    output logic [31:0] hr_read_data,
    output logic        hr_acknowledge,
    output logic        hr_irq,
    output logic        cap_active,
    output logic        cap_frame_start,
    output logic        cap_frame_end
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic              vsync_q, hsync_q;
    logic              vsync_rise, hsync_rise;
    logic              rr_hps;
    logic              n_elig, h_elig, n_grant, h_grant;
    logic [1:0]        g_addr;
    logic              g_rw;
    logic [1:0]        g_wdata;
    logic              g_irq_en;
    logic              g_write, wr_ctrl, wr_irq;
    logic              cmd_arm, cmd_abort;
    logic [31:0]       g_rdata;
    logic              lock_err_set, start_cap;
    logic              done, lock_err;
    logic              nios_irq_en, hps_irq_en;
    logic [LINE_W-1:0] line_cnt, lines_q;
    logic [PIX_W-1:0]  pix_cnt, pixels_q;
    logic              unused_wdata_bits;

    assign unused_wdata_bits = ^{nr_write_data[31:2], hr_write_data[31:2]};

    assign vsync_rise = vid_vsync & ~vsync_q;
    assign hsync_rise = vid_hsync & ~hsync_q;

    // Bus handshake: a master raises bus_enable and holds address/rw/data
    // stable until acknowledge; acknowledge is a one-cycle pulse that carries
    // read_data. A master whose acknowledge is high cannot be granted again.
    assign n_elig  = nr_bus_enable & ~nr_acknowledge;
    assign h_elig  = hr_bus_enable & ~hr_acknowledge;
    assign n_grant = n_elig & (~h_elig | ~rr_hps);
    assign h_grant = h_elig & (~n_elig | rr_hps);

    always_comb begin
        g_addr   = nr_address;
        g_rw     = nr_rw;
        g_wdata  = nr_write_data[1:0];
        g_irq_en = nios_irq_en;
        if (h_grant) begin
            g_addr   = hr_address;
            g_rw     = hr_rw;
            g_wdata  = hr_write_data[1:0];
            g_irq_en = hps_irq_en;
        end
    end

    assign g_write   = (n_grant | h_grant) & ~g_rw;
    assign wr_ctrl   = g_write & (g_addr == 2'd0);
    assign wr_irq    = g_write & (g_addr == 2'd3);
    assign cmd_abort = wr_ctrl & g_wdata[1];
    assign cmd_arm   = wr_ctrl & g_wdata[0] & ~g_wdata[1];

    always_comb begin
        g_rdata = 32'd0;
        case (g_addr)
            2'd0: g_rdata = {26'd0, g_irq_en, lock_err, vid_locked, done,
                             (state == CAPTURE),
                             (state == ARMED) || (state == CAPTURE)};
            2'd1: g_rdata = 32'(lines_q);
            2'd2: g_rdata = 32'(pixels_q);
            default: g_rdata = {30'd0, done, g_irq_en};
        endcase
    end

    always_comb begin
        state_nx     = state;
        lock_err_set = 1'b0;
        start_cap    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_arm) begin
                    if (vid_locked) state_nx = ARMED;
                    else lock_err_set = 1'b1;
                end
            end
            ARMED: begin
                if (cmd_abort) begin
                    state_nx = IDLE;
                end else if (!vid_locked) begin
                    state_nx     = IDLE;
                    lock_err_set = 1'b1;
                end else if (vsync_rise) begin
                    state_nx  = CAPTURE;
                    start_cap = 1'b1;
                end
            end
            CAPTURE: begin
                if (cmd_abort) begin
                    state_nx = IDLE;
                end else if (!vid_locked) begin
                    state_nx     = IDLE;
                    lock_err_set = 1'b1;
                end else if (vsync_rise) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            vsync_q         <= 1'b0;
            hsync_q         <= 1'b0;
            cap_frame_start <= 1'b0;
            cap_frame_end   <= 1'b0;
        end else begin
            state           <= state_nx;
            vsync_q         <= vid_vsync;
            hsync_q         <= vid_hsync;
            cap_frame_start <= start_cap;
            cap_frame_end   <= (state == CAPTURE) && (state_nx == DONE);
        end
    end

    assign cap_active = (state == CAPTURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nr_acknowledge <= 1'b0;
            hr_acknowledge <= 1'b0;
            nr_read_data   <= 32'd0;
            hr_read_data   <= 32'd0;
            rr_hps         <= 1'b0;
        end else begin
            nr_acknowledge <= n_grant;
            hr_acknowledge <= h_grant;
            nr_read_data   <= (n_grant && g_rw) ? g_rdata : 32'd0;
            hr_read_data   <= (h_grant && g_rw) ? g_rdata : 32'd0;
            if (n_elig && h_elig) rr_hps <= ~rr_hps;
        end
    end

    // A done set from DONE outranks a clear issued in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            lock_err    <= 1'b0;
            nios_irq_en <= 1'b0;
            hps_irq_en  <= 1'b0;
            nr_irq      <= 1'b0;
            hr_irq      <= 1'b0;
        end else begin
            if (state == DONE) done <= 1'b1;
            else if (wr_irq && g_wdata[1]) done <= 1'b0;
            if (lock_err_set) lock_err <= 1'b1;
            else if (wr_irq && g_wdata[1]) lock_err <= 1'b0;
            if (wr_irq && n_grant) nios_irq_en <= g_wdata[0];
            if (wr_irq && h_grant) hps_irq_en <= g_wdata[0];
            nr_irq <= done & nios_irq_en;
            hr_irq <= done & hps_irq_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt <= '0;
            pix_cnt  <= '0;
            lines_q  <= '0;
            pixels_q <= '0;
        end else begin
            if (start_cap) begin
                line_cnt <= '0;
                pix_cnt  <= '0;
            end else if (state == CAPTURE) begin
                if (hsync_rise && !(&line_cnt)) line_cnt <= line_cnt + 1'b1;
                if (vid_pixsync && vid_visible && !(&pix_cnt)) pix_cnt <= pix_cnt + 1'b1;
            end
            if (state == DONE) begin
                lines_q  <= line_cnt;
                pixels_q <= pix_cnt;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: register vectors, frame capture,
// arbitration, abort/lock-loss, saturation (narrow instance) and random frames.
module tb_cam_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_pixsync, vid_hsync, vid_vsync, vid_visible, vid_locked;
    logic [1:0]  nr_address, hr_address;
    logic        nr_bus_enable, nr_rw, hr_bus_enable, hr_rw;
    logic [31:0] nr_write_data, hr_write_data;
    logic [31:0] nr_read_data, hr_read_data;
    logic        nr_acknowledge, hr_acknowledge, nr_irq, hr_irq;
    logic        cap_active, cap_frame_start, cap_frame_end;
    logic [31:0] s_nr_read_data, s_hr_read_data;
    logic        s_nr_acknowledge, s_hr_acknowledge, s_nr_irq, s_hr_irq;
    logic        s_cap_active, s_cap_frame_start, s_cap_frame_end;

    int n_checks = 0;
    int n_errors = 0;
    int n_start = 0;
    int n_end = 0;
    int idle_rd_bad = 0;
    bit exp_hps_first = 1'b0;
    logic [31:0] s_n_rd, s_h_rd;

    always #10 clk = ~clk;

    cam_capture_ctrl dut (
        .clk(clk), .rst(rst),
        .vid_pixsync(vid_pixsync), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .vid_visible(vid_visible), .vid_locked(vid_locked),
        .nr_address(nr_address), .nr_bus_enable(nr_bus_enable), .nr_rw(nr_rw),
        .nr_write_data(nr_write_data), .nr_read_data(nr_read_data),
        .nr_acknowledge(nr_acknowledge), .nr_irq(nr_irq),
        .hr_address(hr_address), .hr_bus_enable(hr_bus_enable), .hr_rw(hr_rw),
        .hr_write_data(hr_write_data), .hr_read_data(hr_read_data),
        .hr_acknowledge(hr_acknowledge), .hr_irq(hr_irq),
        .cap_active(cap_active), .cap_frame_start(cap_frame_start),
        .cap_frame_end(cap_frame_end)
    );

    // Narrow counters so saturation is reachable in a short frame.
    cam_capture_ctrl #(.LINE_W(3), .PIX_W(6)) sdut (
        .clk(clk), .rst(rst),
        .vid_pixsync(vid_pixsync), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .vid_visible(vid_visible), .vid_locked(vid_locked),
        .nr_address(nr_address), .nr_bus_enable(nr_bus_enable), .nr_rw(nr_rw),
        .nr_write_data(nr_write_data), .nr_read_data(s_nr_read_data),
        .nr_acknowledge(s_nr_acknowledge), .nr_irq(s_nr_irq),
        .hr_address(hr_address), .hr_bus_enable(hr_bus_enable), .hr_rw(hr_rw),
        .hr_write_data(hr_write_data), .hr_read_data(s_hr_read_data),
        .hr_acknowledge(s_hr_acknowledge), .hr_irq(s_hr_irq),
        .cap_active(s_cap_active), .cap_frame_start(s_cap_frame_start),
        .cap_frame_end(s_cap_frame_end)
    );

    always @(negedge clk) begin
        if (cap_frame_start) n_start++;
        if (cap_frame_end) n_end++;
        if (!nr_acknowledge && nr_read_data != 32'd0) idle_rd_bad++;
        if (!hr_acknowledge && hr_read_data != 32'd0) idle_rd_bad++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both masters present together; each holds bus_enable through its
    // acknowledge cycle and releases it one cycle later.
    task automatic dual_op(input bit n_go, input logic [1:0] n_a, input bit n_rw, input logic [31:0] n_wd,
                           input bit h_go, input logic [1:0] h_a, input bit h_rw, input logic [31:0] h_wd,
                           output logic [31:0] n_rd, output logic [31:0] h_rd);
        int n_lat, h_lat, n_acks, h_acks, n_exp, h_exp;
        bit n_done, h_done;
        n_lat = 0; h_lat = 0; n_acks = 0; h_acks = 0;
        n_rd = '0; h_rd = '0;
        n_done = !n_go; h_done = !h_go;
        if (n_go && h_go) begin
            n_exp = exp_hps_first ? 2 : 1;
            h_exp = exp_hps_first ? 1 : 2;
            exp_hps_first = !exp_hps_first;
        end else begin
            n_exp = 1;
            h_exp = 1;
        end
        nr_address = n_a; nr_rw = n_rw; nr_write_data = n_wd; nr_bus_enable = n_go;
        hr_address = h_a; hr_rw = h_rw; hr_write_data = h_wd; hr_bus_enable = h_go;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (nr_acknowledge) n_acks++;
            if (hr_acknowledge) h_acks++;
            if (n_done) nr_bus_enable = 1'b0;
            if (h_done) hr_bus_enable = 1'b0;
            if (!n_done) begin
                n_lat++;
                if (nr_acknowledge) begin
                    n_done = 1'b1; n_rd = nr_read_data; s_n_rd = s_nr_read_data;
                end
            end
            if (!h_done) begin
                h_lat++;
                if (hr_acknowledge) begin
                    h_done = 1'b1; h_rd = hr_read_data; s_h_rd = s_hr_read_data;
                end
            end
            if (n_done && h_done && !nr_bus_enable && !hr_bus_enable) break;
        end
        tick();
        if (nr_acknowledge) n_acks++;
        if (hr_acknowledge) h_acks++;
        nr_bus_enable = 1'b0;
        hr_bus_enable = 1'b0;
        if (n_go) check("nios_ack_latency", n_lat, n_exp);
        if (h_go) check("hps_ack_latency", h_lat, h_exp);
        check("nios_ack_count", n_acks, {31'd0, n_go});
        check("hps_ack_count", h_acks, {31'd0, h_go});
    endtask

    task automatic op(input bit m, input logic [1:0] a, input bit rw, input logic [31:0] wd,
                      output logic [31:0] rd);
        logic [31:0] dummy;
        if (m) dual_op(1'b0, 2'd0, 1'b1, 32'd0, 1'b1, a, rw, wd, dummy, rd);
        else   dual_op(1'b1, a, rw, wd, 1'b0, 2'd0, 1'b1, 32'd0, rd, dummy);
    endtask

    task automatic wr(input bit m, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        op(m, a, 1'b0, d, r);
    endtask

    task automatic rd_chk(input bit m, input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] r;
        op(m, a, 1'b1, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic vsync_pulse();
        vid_vsync = 1'b1;
        tick(); tick();
        vid_vsync = 1'b0;
        tick();
    endtask

    task automatic line(input int vis, input int invis);
        vid_hsync = 1'b1;
        tick();
        vid_hsync = 1'b0;
        tick();
        for (int i = 0; i < vis + invis; i++) begin
            vid_pixsync = 1'b1;
            vid_visible = (i < vis);
            tick();
            vid_pixsync = 1'b0;
            vid_visible = 1'b0;
            tick();
        end
    endtask

    task automatic frame(input int nl, input int vis_lo, input int vis_hi, input int invis,
                         output int total);
        int v;
        total = 0;
        vsync_pulse();
        for (int l = 0; l < nl; l++) begin
            v = $urandom_range(vis_hi, vis_lo);
            total += v;
            line(v, invis);
        end
        vsync_pulse();
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    typedef struct {
        bit          m;
        logic [1:0]  a;
        bit          rw;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rn, rh;
        int s0, e0, tot, nl;
        bit m;

        rst = 1'b1;
        vid_pixsync = 1'b0; vid_hsync = 1'b0; vid_vsync = 1'b0;
        vid_visible = 1'b0; vid_locked = 1'b1;
        nr_address = '0; nr_bus_enable = 1'b0; nr_rw = 1'b1; nr_write_data = '0;
        hr_address = '0; hr_bus_enable = 1'b0; hr_rw = 1'b1; hr_write_data = '0;

        vecs[0] = '{1'b0, 2'd0, 1'b1, 32'd0,      32'h8};
        vecs[1] = '{1'b1, 2'd0, 1'b1, 32'd0,      32'h8};
        vecs[2] = '{1'b0, 2'd1, 1'b1, 32'd0,      32'h0};
        vecs[3] = '{1'b1, 2'd2, 1'b1, 32'd0,      32'h0};
        vecs[4] = '{1'b1, 2'd1, 1'b0, 32'hFFFF,   32'h0};
        vecs[5] = '{1'b0, 2'd1, 1'b1, 32'd0,      32'h0};
        vecs[6] = '{1'b0, 2'd3, 1'b0, 32'h1,      32'h0};
        vecs[7] = '{1'b0, 2'd3, 1'b1, 32'd0,      32'h1};
        vecs[8] = '{1'b1, 2'd3, 1'b1, 32'd0,      32'h0};
        vecs[9] = '{1'b0, 2'd0, 1'b1, 32'd0,      32'h28};

        tick(); tick(); tick();
        check("reset_nr_ack", {31'd0, nr_acknowledge}, 32'd0);
        check("reset_irqs", {30'd0, nr_irq, hr_irq}, 32'd0);
        check("reset_cap", {29'd0, cap_active, cap_frame_start, cap_frame_end}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            op(vecs[i].m, vecs[i].a, vecs[i].rw, vecs[i].wd, rn);
            if (vecs[i].rw) check($sformatf("vec%0d_rdata", i), rn, vecs[i].exp);
        end

        // Nominal 4 x 10 frame with NIOS irq enabled.
        s0 = n_start; e0 = n_end;
        wr(1'b0, 2'd0, 32'h1);
        rd_chk(1'b0, 2'd0, 32'h29, "ctrl_armed");
        vsync_pulse();
        check("cap_active_in_capture", {31'd0, cap_active}, 32'd1);
        rd_chk(1'b0, 2'd0, 32'h2B, "ctrl_capturing");
        for (int l = 0; l < 4; l++) line(10, 8);
        vsync_pulse();
        check("cap_active_after_frame", {31'd0, cap_active}, 32'd0);
        check("frame_start_pulses", n_start - s0, 32'd1);
        check("frame_end_pulses", n_end - e0, 32'd1);
        check("nr_irq_done", {31'd0, nr_irq}, 32'd1);
        check("hr_irq_done", {31'd0, hr_irq}, 32'd0);
        rd_chk(1'b0, 2'd1, 32'd4, "lines_4");
        rd_chk(1'b0, 2'd2, 32'd40, "pixels_40");
        rd_chk(1'b0, 2'd0, 32'h2C, "ctrl_done");
        rd_chk(1'b0, 2'd3, 32'h3, "nios_irq_reg");
        rd_chk(1'b1, 2'd3, 32'h2, "hps_irq_reg");
        wr(1'b1, 2'd3, 32'h2);
        check("nr_irq_cleared", {31'd0, nr_irq}, 32'd0);
        rd_chk(1'b0, 2'd0, 32'h28, "ctrl_after_clear");

        // Repeated contention: NIOS first, then HPS, then NIOS.
        for (int k = 0; k < 3; k++) begin
            dual_op(1'b1, 2'd0, 1'b1, 32'd0, 1'b1, 2'd0, 1'b1, 32'd0, rn, rh);
            check("contend_nios_data", rn, 32'h28);
            check("contend_hps_data", rh, 32'h8);
        end

        // Abort mid-capture, then ARM+ABORT from ARMED.
        wr(1'b0, 2'd0, 32'h1);
        vsync_pulse();
        line(10, 8); line(10, 8);
        check("cap_active_before_abort", {31'd0, cap_active}, 32'd1);
        wr(1'b0, 2'd0, 32'h2);
        rd_chk(1'b0, 2'd0, 32'h28, "ctrl_after_abort");
        rd_chk(1'b1, 2'd1, 32'd4, "lines_kept");
        rd_chk(1'b1, 2'd2, 32'd40, "pixels_kept");
        wr(1'b0, 2'd0, 32'h1);
        rd_chk(1'b0, 2'd0, 32'h29, "ctrl_rearmed");
        wr(1'b0, 2'd0, 32'h3);
        rd_chk(1'b0, 2'd0, 32'h28, "ctrl_arm_abort");

        // Lock loss during capture, then ARM while unlocked.
        wr(1'b0, 2'd0, 32'h1);
        vsync_pulse();
        line(5, 0);
        vid_locked = 1'b0;
        tick(); tick();
        check("cap_active_lock_loss", {31'd0, cap_active}, 32'd0);
        rd_chk(1'b0, 2'd0, 32'h30, "ctrl_lock_err");
        wr(1'b0, 2'd0, 32'h1);
        rd_chk(1'b0, 2'd0, 32'h30, "ctrl_arm_unlocked");
        vid_locked = 1'b1;
        wr(1'b0, 2'd3, 32'h3);
        rd_chk(1'b0, 2'd0, 32'h28, "ctrl_lock_err_cleared");

        // Saturation: 9 lines x 10 pixels against 3-bit / 6-bit counters.
        wr(1'b0, 2'd0, 32'h1);
        frame(9, 10, 10, 0, tot);
        dual_op(1'b1, 2'd1, 1'b1, 32'd0, 1'b1, 2'd2, 1'b1, 32'd0, rn, rh);
        check("lines_9", rn, 32'd9);
        check("pixels_90", rh, 32'd90);
        check("narrow_lines_sat", s_n_rd, 32'h7);
        check("narrow_pixels_sat", s_h_rd, 32'h3F);
        check("narrow_nr_irq", {31'd0, s_nr_irq}, 32'd1);

        // Reset in the middle of a frame with an IRQ pending.
        wr(1'b0, 2'd0, 32'h1);
        vsync_pulse();
        line(5, 0);
        check("nr_irq_before_reset", {31'd0, nr_irq}, 32'd1);
        check("cap_active_before_reset", {31'd0, cap_active}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("nr_irq_async_reset", {31'd0, nr_irq}, 32'd0);
        check("cap_active_async_reset", {31'd0, cap_active}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        exp_hps_first = 1'b0;
        tick();
        rd_chk(1'b0, 2'd0, 32'h8, "ctrl_after_reset");
        rd_chk(1'b1, 2'd1, 32'd0, "lines_after_reset");

        // Random frames against arithmetic expectations.
        wr(1'b0, 2'd3, 32'h1);
        for (int f = 0; f < 6; f++) begin
            m = 1'($urandom_range(1, 0));
            nl = $urandom_range(10, 1);
            wr(m, 2'd0, 32'h1);
            frame(nl, 0, 12, $urandom_range(4, 0), tot);
            dual_op(1'b1, 2'd1, 1'b1, 32'd0, 1'b1, 2'd2, 1'b1, 32'd0, rn, rh);
            check($sformatf("rand%0d_lines", f), rn, nl);
            check($sformatf("rand%0d_pixels", f), rh, tot);
            check($sformatf("rand%0d_narrow_lines", f), s_n_rd, sat(nl, 7));
            check($sformatf("rand%0d_narrow_pixels", f), s_h_rd, sat(tot, 63));
            check($sformatf("rand%0d_nr_irq", f), {31'd0, nr_irq}, 32'd1);
            wr(1'b1, 2'd3, 32'h2);
        end

        // Random idle-register traffic with random contention.
        for (int k = 0; k < 10; k++) begin
            bit ng, hg;
            logic [1:0] na, ha;
            logic [31:0] en, eh;
            ng = 1'($urandom_range(1, 0));
            hg = 1'($urandom_range(1, 0));
            na = 2'($urandom_range(3, 0));
            ha = 2'($urandom_range(3, 0));
            en = (na == 2'd0) ? 32'h28 : (na == 2'd1) ? nl : (na == 2'd2) ? tot : 32'h1;
            eh = (ha == 2'd0) ? 32'h08 : (ha == 2'd1) ? nl : (ha == 2'd2) ? tot : 32'h0;
            dual_op(ng, na, 1'b1, 32'd0, hg, ha, 1'b1, 32'd0, rn, rh);
            if (ng) check($sformatf("traffic%0d_nios", k), rn, en);
            if (hg) check($sformatf("traffic%0d_hps", k), rh, eh);
        end

        check("read_data_zero_without_ack", idle_rd_bad, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
